// File: rtl/d_write_buffer.sv
// Posted-write FIFO between the data cache and block RAM with read forwarding and a flush handshake.
// Optional WBUF_COALESCE_EN: pushes to an already-buffered address update that entry in place.
module d_write_buffer #(
   parameter int DEPTH = 4,
   parameter int AW    = 32,
   parameter int DW    = 32
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     wb_req,
   input  logic [AW-1:0]            wb_addr,
   input  logic [DW-1:0]            wb_data,
   output logic                     wb_full,
   input  logic                     rd_req,
   input  logic [AW-1:0]            rd_addr,
   output logic                     rd_hit,
   output logic [DW-1:0]            rd_data,
   input  logic                     mem_ready,
   output logic                     mem_we,
   output logic [AW-1:0]            mem_addr,
   output logic [DW-1:0]            mem_wdata,
   input  logic                     flush_req,
   output logic                     flush_done,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PW = $clog2(DEPTH);

   typedef enum logic [1:0] {IDLE, FLUSH, DONE} state_t;

   state_t        state;
   logic [PW-1:0] head, tail;
   logic [AW-1:0] addr_q [DEPTH];
   logic [DW-1:0] data_q [DEPTH];

   logic          push, pop, alloc;
   logic [PW:0]   count_next;
   logic          ent_hit, push_match;
   logic [DW-1:0] ent_data;
   logic [PW-1:0] idx;
`ifdef WBUF_COALESCE_EN
   logic          coal_hit;
   logic [PW-1:0] coal_idx;
`endif

   assign empty     = (count == '0);
   assign pop       = ~empty & mem_ready;
   assign mem_we    = pop;
   assign mem_addr  = addr_q[head];
   assign mem_wdata = data_q[head];

   // Walk oldest to youngest so the last match found is the youngest.
   always_comb begin
      ent_hit  = 1'b0;
      ent_data = '0;
      idx      = '0;
`ifdef WBUF_COALESCE_EN
      coal_hit = 1'b0;
      coal_idx = '0;
`endif
      for (int unsigned k = 0; k < DEPTH; k++) begin
         idx = head + PW'(k);
         if ((PW+1)'(k) < count) begin
            if (addr_q[idx] == rd_addr) begin
               ent_hit  = 1'b1;
               ent_data = data_q[idx];
            end
`ifdef WBUF_COALESCE_EN
            if ((addr_q[idx] == wb_addr) && ((k != 0) || !pop)) begin
               coal_hit = 1'b1;
               coal_idx = idx;
            end
`endif
         end
      end
   end

`ifdef WBUF_COALESCE_EN
   assign wb_full = (state == FLUSH) | ((count == (PW+1)'(DEPTH)) & ~coal_hit);
   assign push    = wb_req & ~wb_full;
   assign alloc   = push & ~coal_hit;
`else
   assign wb_full = (state == FLUSH) | (count == (PW+1)'(DEPTH));
   assign push    = wb_req & ~wb_full;
   assign alloc   = push;
`endif

   always_comb begin
      case ({alloc, pop})
         2'b10:   count_next = count + 1'b1;
         2'b01:   count_next = count - 1'b1;
         default: count_next = count;
      endcase
   end

   assign push_match = push & (wb_addr == rd_addr);
   assign rd_hit     = rd_req & (push_match | ent_hit);

   always_comb begin
      rd_data = '0;
      if (rd_req) begin
         if (push_match)   rd_data = wb_data;
         else if (ent_hit) rd_data = ent_data;
      end
   end

   always_ff @(posedge clk) begin
      if (alloc) begin
         addr_q[tail] <= wb_addr;
         data_q[tail] <= wb_data;
      end
`ifdef WBUF_COALESCE_EN
      else if (push) begin
         data_q[coal_idx] <= wb_data;
      end
`endif
   end

   // FLUSH exits on the edge that empties the buffer so the done pulse follows the last pop.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         head       <= '0;
         tail       <= '0;
         count      <= '0;
         state      <= IDLE;
         flush_done <= 1'b0;
      end else begin
         if (alloc) tail <= tail + 1'b1;
         if (pop)   head <= head + 1'b1;
         count      <= count_next;
         flush_done <= 1'b0;
         case (state)
            IDLE:    if (flush_req) state <= FLUSH;
            FLUSH:   if (count_next == '0) begin
                        state      <= DONE;
                        flush_done <= 1'b1;
                     end
            DONE:    state <= flush_req ? FLUSH : IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_d_write_buffer.sv
// Scoreboard bench for d_write_buffer: drain writes are checked against an expected-entry queue.
module tb_d_write_buffer;

   localparam int DEPTH = 4;
   localparam int AW    = 32;
   localparam int DW    = 32;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          wb_req = 1'b0;
   logic [AW-1:0] wb_addr = '0;
   logic [DW-1:0] wb_data = '0;
   logic          wb_full;
   logic          rd_req = 1'b0;
   logic [AW-1:0] rd_addr = '0;
   logic          rd_hit;
   logic [DW-1:0] rd_data;
   logic          mem_ready = 1'b0;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic          flush_req = 1'b0;
   logic          flush_done;
   logic          empty;
   logic [$clog2(DEPTH):0] count;

   d_write_buffer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
      .clk(clk), .rst(rst),
      .wb_req(wb_req), .wb_addr(wb_addr), .wb_data(wb_data), .wb_full(wb_full),
      .rd_req(rd_req), .rd_addr(rd_addr), .rd_hit(rd_hit), .rd_data(rd_data),
      .mem_ready(mem_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .flush_req(flush_req), .flush_done(flush_done), .empty(empty), .count(count)
   );

   always #5 clk = ~clk;

   typedef struct { logic [AW-1:0] a; logic [DW-1:0] d; } ent_t;
   ent_t exp_q[$];

   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      n_chk++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got %h, required %h (t=%0t)", name, act, req, $time);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push_exp(input logic [AW-1:0] a, input logic [DW-1:0] d);
      ent_t e;
      e.a = a;
      e.d = d;
      exp_q.push_back(e);
   endtask

   task automatic drain_all(input int max_cycles);
      int n;
      n = 0;
      mem_ready = 1'b1;
      while (!empty && n < max_cycles) begin
         step();
         n++;
      end
      chk("drain_to_empty", empty, 1);
      chk("scoreboard_drained", exp_q.size(), 0);
   endtask

   // Scoreboard monitor: every drain write must match the oldest expected entry.
   always @(negedge clk) begin
      if (rst && mem_we) begin
         if (exp_q.size() == 0) begin
            n_chk++;
            $display("FAIL drain_unexpected: got addr %h data %h, required no write", mem_addr, mem_wdata);
         end else begin
            ent_t e;
            e = exp_q.pop_front();
            chk("drain_addr", mem_addr, e.a);
            chk("drain_data", mem_wdata, e.d);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic mr_seq [4];
      mr_seq[0] = 1'b1; mr_seq[1] = 1'b0; mr_seq[2] = 1'b1; mr_seq[3] = 1'b1;

      // Reset state
      #2;
      chk("rst_count", count, 0);
      chk("rst_empty", empty, 1);
      chk("rst_wb_full", wb_full, 0);
      chk("rst_mem_we", mem_we, 0);
      chk("rst_flush_done", flush_done, 0);
      step();
      rst = 1'b1;

      // Fill and drain
      mem_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         wb_req  = 1'b1;
         wb_addr = 32'h10 + 32'(4 * i);
         wb_data = 32'(i + 1);
         push_exp(wb_addr, wb_data);
         step();
      end
      chk("fill_count", count, 4);
      chk("fill_full", wb_full, 1);
      wb_addr = 32'h50;
      wb_data = 32'h5;
      step();
      wb_req = 1'b0;
      chk("fifth_push_refused", count, 4);
      mem_ready = 1'b1;
      repeat (4) step();
      chk("drain4_empty", empty, 1);
      chk("drain4_scoreboard", exp_q.size(), 0);
      mem_ready = 1'b0;

      // Forwarding and same-cycle bypass
      wb_req = 1'b1; wb_addr = 32'h20; wb_data = 32'hAAAA;
`ifndef WBUF_COALESCE_EN
      push_exp(32'h20, 32'hAAAA);
`endif
      step();
      wb_data = 32'hBBBB;
      push_exp(32'h20, 32'hBBBB);
      step();
      wb_req = 1'b0;
`ifdef WBUF_COALESCE_EN
      chk("fwd_coalesced_count", count, 1);
`else
      chk("fwd_dup_count", count, 2);
`endif
      rd_req = 1'b1; rd_addr = 32'h20;
      #1;
      chk("fwd_hit", rd_hit, 1);
      chk("fwd_youngest", rd_data, 32'hBBBB);
      rd_addr = 32'h24;
      #1;
      chk("fwd_miss_hit", rd_hit, 0);
      chk("fwd_miss_data", rd_data, 0);
      rd_req = 1'b0; rd_addr = 32'h20;
      #1;
      chk("fwd_noreq_hit", rd_hit, 0);
      chk("fwd_noreq_data", rd_data, 0);
      step();
      wb_req = 1'b1; wb_addr = 32'h30; wb_data = 32'h55;
      rd_req = 1'b1; rd_addr = 32'h30;
      push_exp(32'h30, 32'h55);
      #1;
      chk("bypass_hit", rd_hit, 1);
      chk("bypass_data", rd_data, 32'h55);
      step();
      wb_req = 1'b0; rd_req = 1'b0;
      drain_all(8);
      mem_ready = 1'b0;

      // Flush with 3 entries and mem_ready toggling
      for (int i = 0; i < 3; i++) begin
         wb_req = 1'b1; wb_addr = 32'h60 + 32'(4 * i); wb_data = 32'(6 + i);
         push_exp(wb_addr, wb_data);
         step();
      end
      wb_req = 1'b0;
      flush_req = 1'b1;
      step();
      flush_req = 1'b0;
      wb_req = 1'b1; wb_addr = 32'h70; wb_data = 32'h77;
      for (int j = 0; j < 4; j++) begin
         mem_ready = mr_seq[j];
         #1;
         chk("flush_wb_full", wb_full, 1);
         chk("flush_done_early", flush_done, 0);
         step();
      end
      wb_req = 1'b0; mem_ready = 1'b0;
      chk("flush_done_pulse", flush_done, 1);
      chk("flush_emptied", empty, 1);
      step();
      chk("flush_done_single", flush_done, 0);
      chk("flush_exit_full", wb_full, 0);
      chk("flush_scoreboard", exp_q.size(), 0);

      // Flush with the buffer already empty
      flush_req = 1'b1;
      step();
      flush_req = 1'b0;
      chk("eflush_not_yet", flush_done, 0);
      step();
      chk("eflush_done", flush_done, 1);
      step();
      chk("eflush_single", flush_done, 0);

      // Ten push/pop pairs across the pointer wrap
      mem_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         wb_req = 1'b1; wb_addr = 32'h100 + 32'(4 * i); wb_data = 32'hD0 + 32'(i);
         push_exp(wb_addr, wb_data);
         step();
      end
      wb_req = 1'b0;
      step();
      chk("wrap_empty", empty, 1);
      chk("wrap_scoreboard", exp_q.size(), 0);

      // Asynchronous reset mid-drain
      mem_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         wb_req = 1'b1; wb_addr = 32'h200 + 32'(4 * i); wb_data = 32'hE0 + 32'(i);
         push_exp(wb_addr, wb_data);
         step();
      end
      wb_req = 1'b0;
      mem_ready = 1'b1;
      step();
      #2;
      rst = 1'b0;
      #1;
      chk("arst_mem_we", mem_we, 0);
      chk("arst_count", count, 0);
      chk("arst_wb_full", wb_full, 0);
      chk("arst_empty", empty, 1);
      exp_q.delete();
      step();
      rst = 1'b1;
      mem_ready = 1'b0;
      step();
      chk("arst_release_count", count, 0);

`ifdef WBUF_COALESCE_EN
      // Coalescing
      wb_req = 1'b1; wb_addr = 32'h40; wb_data = 32'h1;
      push_exp(32'h40, 32'h1);
      step();
      wb_addr = 32'h44; wb_data = 32'h2;
      step();
      wb_data = 32'h3;
      push_exp(32'h44, 32'h3);
      step();
      wb_req = 1'b0;
      chk("coal_count", count, 2);
      drain_all(6);
      mem_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         wb_req = 1'b1; wb_addr = 32'h50 + 32'(4 * i); wb_data = 32'h11 + 32'(i);
         push_exp(wb_addr, (i == 1) ? 32'h99 : wb_data);
         step();
      end
      wb_addr = 32'h54; wb_data = 32'h99;
      #1;
      chk("coal_full_match_accept", wb_full, 0);
      step();
      chk("coal_full_count", count, 4);
      wb_addr = 32'h60; wb_data = 32'h66;
      #1;
      chk("coal_full_nomatch", wb_full, 1);
      step();
      wb_req = 1'b0;
      rd_req = 1'b1; rd_addr = 32'h54;
      #1;
      chk("coal_fwd_data", rd_data, 32'h99);
      rd_req = 1'b0;
      drain_all(8);
      mem_ready = 1'b0;
`endif

      step();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/d_write_buffer.md
# d_write_buffer

Posted-write FIFO between the data cache and the data block RAM. Dirty-line writebacks from `d_cache` are pushed here and drained to BM port A in order, so a read miss that evicts a dirty line does not wait for the writeback. Read misses probe the buffer first so data still in flight is forwarded instead of stale RAM contents. A flush handshake drains the buffer completely, for example before a fence or a debug memory dump.

## Interface
Parameters:
- `DEPTH`, 4: number of entries; power of two, 2..16
- `AW`, 32: address width
- `DW`, 32: data width

Ports:
- `clk`  in  1  clock; all state updates on the rising edge
- `rst`  in  1  asynchronous, active-low reset
- `wb_req`  in  1  push request from the cache
- `wb_addr`  in  AW  writeback word address
- `wb_data`  in  DW  writeback data
- `wb_full`  out  1  push refused this cycle
- `rd_req`  in  1  read-miss probe from the cache
- `rd_addr`  in  AW  probe address
- `rd_hit`  out  1  probe matches buffered or in-push data (combinational)
- `rd_data`  out  DW  forwarded data; valid when `rd_hit`
- `mem_ready`  in  1  RAM write port free this cycle
- `mem_we`  out  1  drain write strobe
- `mem_addr`  out  AW  drain address (head entry)
- `mem_wdata`  out  DW  drain data (head entry)
- `flush_req`  in  1  level request to drain to empty
- `flush_done`  out  1  one-cycle pulse when a flush completes
- `empty`  out  1  no valid entries
- `count`  out  $clog2(DEPTH)+1  number of valid entries

## Operation
- Storage is a circular FIFO with registered head and tail pointers of width $clog2(DEPTH), plus `count`. Pointers wrap from DEPTH-1 to 0.
- **Push accept:** `wb_req & ~wb_full`. The entry is written at the tail, and the tail and count are updated at the edge.
- **`wb_full`:** `(count == DEPTH) | (state == FLUSH)`. A push is refused when full even if a pop happens in the same cycle.
- **Drain:** `mem_we = ~empty & mem_ready`. `mem_addr` and `mem_wdata` come combinationally from the head entry. The head advances at the edge when `mem_we` is high.
- **Simultaneous push and pop:** count is unchanged, and both pointers advance.
- **Forwarding:**
  - `rd_hit` is high if `rd_req` and either an accepted push this cycle has `wb_addr == rd_addr`, or any valid entry has a matching address.
  - Priority for `rd_data`: the same-cycle push first, then the youngest matching entry (the one closest to the tail).
  - With no `rd_req`, `rd_hit` is 0 and `rd_data` is 0.
- **FSM:**
  - IDLE goes to FLUSH on `flush_req`.
  - FLUSH goes to DONE when `count == 0`. This includes the case where the buffer is already empty on entry.
  - DONE asserts `flush_done` for 1 cycle, then returns to IDLE. `flush_req` must be deasserted by then; if it is still high, a new flush starts.
  - Pushes are blocked in FLUSH only.

## Timing
- Reset values:
  - Pointers and `count` are 0, `empty` is 1, `wb_full` is 0.
  - `mem_we` is 0 (no entries).
  - `flush_done` is 0, the FSM is in IDLE.
  - Entry storage is don't-care.
- Reset asserted mid-operation discards all entries immediately; no partial drain is completed.
- Push-to-drain latency: an entry pushed at edge N can be drained at the earliest in the cycle after edge N (`mem_we` high), provided it is at the head and `mem_ready` is high.
- Forwarding has zero latency, including the same-cycle push bypass.
- A flush issued with k entries and `mem_ready` held high gives `flush_done` high in the cycle after the edge that pops the last entry. Total: k+1 cycles after entering FLUSH, FLUSH being entered 1 edge after `flush_req`.
- `empty`, `count` and `wb_full` are registered-state decodes with no combinational path from `wb_req`.

## Configuration
- **`WBUF_COALESCE_EN` defined:**
  - A push whose address matches a valid non-head entry overwrites that entry's data in place; no allocation, and count is unchanged.
  - A match only at the head while the head is popping this cycle allocates a new entry instead.
  - A coalescing push is accepted even when `count == DEPTH`: `wb_full` then means "full and no match", so it becomes combinational on `wb_addr`.
- **Undefined:** every accepted push allocates a new entry. Duplicate addresses may coexist, and forwarding returns the youngest.

## Test plan
- **Fill and drain:** with `mem_ready` held 0, push addresses 0x10, 0x14, 0x18, 0x1C with data 1..4.
  - `wb_full` goes to 1 and `count` to 4.
  - A 5th push is refused.
  - Raising `mem_ready` gives 4 consecutive `mem_we` with addresses in order, then `empty` is 1.
- **Forwarding:** buffer holds 0x20 = 0xAAAA and 0x20 = 0xBBBB (coalescing off); probe 0x20 gives `rd_hit` 1 and `rd_data` 0xBBBB. Probe 0x24 gives `rd_hit` 0.
- **Same-cycle bypass:** push 0x30 = 0x55 while probing 0x30 in the same cycle gives `rd_hit` 1 and `rd_data` 0x55.
- **Flush:** with 3 entries, `mem_ready` toggling 1,0,1,1, and `flush_req` pulsed:
  - `wb_full` is high throughout FLUSH.
  - `flush_done` pulses exactly once, in the cycle after the last pop.
  - A flush with the buffer empty gives `flush_done` 2 cycles after `flush_req`.
- **Wrap and reset:**
  - Run 10 pushes and pops with DEPTH 4 and check drain order across the pointer wrap.
  - Assert `rst` low asynchronously mid-drain: `mem_we`, `count` and `wb_full` drop to 0 and `empty` rises before the next edge.
- **Coalesce (macro on):** with `mem_ready` 0, push 0x40 = 1, then 0x44 = 2, then 0x44 = 3. Expect `count` 2, the drain gives 0x44 = 3, and with 4 entries a matching push is still accepted.
